// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
// Holds the opcode constants, the 4-bit state encoding (exposed on the debug
// port), the datapath select encodings and the packed control vector that
// the output decoder produces.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b010001;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTYPE  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_mem_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Combinational control-vector decoder.
// Ports: state_i (current FSM state), mem_ready_i (memory completion),
//        ctrl_o (all datapath enables/selects).
// Outputs depend on the state only, except IRWrite/PCWrite in FETCH, which
// fire only in the cycle the instruction word actually arrives.
module mips_multicycle_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: ctrl_o.alu_src_b = SRCB_SHIMM;
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_RTYPE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDIWB: ctrl_o.reg_write = 1'b1;
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            // JAL writes r31 with next_pc; the downstream mux swaps in those
            // operands while reg_write is high for this single cycle.
            S_JAL: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
                ctrl_o.reg_write = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath.
// Ports: clk, rst_n (async, active low), opcode (IR[31:26]), zero (ALU flag),
//        mem_ready (memory handshake), datapath enables/selects,
//        illegal_op (pulse), mem_timeout (sticky), state (debug).
// Memory handshake: a strobe (MemRead/MemWrite) stays asserted from the
// first cycle of FETCH/MEMRD/MEMWR; the access completes in the cycle
// mem_ready is sampled high, and the FSM leaves on that clock edge. There is
// no separate valid; mem_ready outside those states is ignored.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W    = 6,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite_from_controlUnit,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [3:0]       state
);

    localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_MAX);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       illegal_q, illegal_d;
    ctrl_t      ctrl;
    logic       waiting;
    logic       entering_wait;

    // zero is consumed by the datapath's PCWriteCond gate, not by the FSM.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTYPE:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_JAL:    state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // The counter restarts for every memory access; it saturates at the
    // limit so a very long stall cannot wrap it. The FSM keeps waiting.
    assign waiting       = is_mem_wait_state(state_q) && !mem_ready;
    assign entering_wait = (state_d != state_q) && is_mem_wait_state(state_d);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (entering_wait) begin
            wait_cnt_d = '0;
        end else if (waiting && (wait_cnt_q != WAIT_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
            if (wait_cnt_q + 4'd1 == WAIT_LIMIT) timeout_d = 1'b1;
        end
    end

    mips_multicycle_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign PCWrite                   = ctrl.pc_write;
    assign PCWriteCond               = ctrl.pc_write_cond;
    assign IorD                      = ctrl.iord;
    assign MemRead                   = ctrl.mem_read;
    assign MemWrite                  = ctrl.mem_write;
    assign IRWrite                   = ctrl.ir_write;
    assign MemtoReg                  = ctrl.mem_to_reg;
    assign RegDst                    = ctrl.reg_dst;
    assign RegWrite_from_controlUnit = ctrl.reg_write;
    assign ALUSrcA                   = ctrl.alu_src_a;
    assign ALUSrcB                   = ctrl.alu_src_b;
    assign ALUOp                     = ctrl.alu_op;
    assign PCSource                  = ctrl.pc_source;
    assign illegal_op                = illegal_q;
    assign mem_timeout               = timeout_q;
    assign state                     = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM of the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and select, including RegWrite_from_controlUnit, which feeds the JAL write-register/write-data mux directly downstream.
- Also owns a one-signal wait handshake with the unified instruction/data memory.

Parameters:
- OPC_W, 6, opcode field width
- WAIT_MAX, 15, maximum mem_ready wait cycles before mem_timeout is flagged

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if zero
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- RegDst  out  1  0 = rt, 1 = rd
- RegWrite_from_controlUnit  out  1  register file write request, consumed by the JAL mux
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- mem_timeout  out  1  sticky error flag, cleared only by reset
- state  out  4  current state, for debug

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state = IDLE, all control outputs 0, illegal_op = 0, mem_timeout = 0.
- Output type: Moore. Outputs decode from the state register only; the exceptions are the mem_ready-gated strobes below.
- Opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, JAL 010001.

States and transitions:
- IDLE: all outputs 0. Goes to FETCH on the first clk after reset release.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite assert only when mem_ready=1; FETCH then goes to DECODE.
  - If mem_ready=0, stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Branches on opcode:
  - LW/SW -> MEMADR; R -> RTYPE; BEQ -> BEQ; ADDI -> ADDIEX; J -> JUMP; JAL -> JAL.
  - Any other opcode -> FETCH, with illegal_op pulsing for one cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Goes to MEMWB on mem_ready, else holds.
- MEMWB: RegWrite_from_controlUnit=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Goes to FETCH on mem_ready, else holds.
- RTYPE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegWrite_from_controlUnit=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RegWrite_from_controlUnit=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite_from_controlUnit=1. Goes to FETCH.
  - The downstream mux substitutes r31 and next_pc.
  - RegWrite is high for exactly one cycle, which also delivers the rising edge that mux's event list depends on.

Latency with mem_ready tied to 1:
- LW 5 cycles; SW, R-type, ADDI 4 cycles; BEQ, J, JAL 3 cycles.
- IDLE adds 1 cycle only after reset.

RegWrite timing:
- RegWrite_from_controlUnit is never high in two consecutive cycles.
- It always returns to 0 in the FETCH that follows a writeback state.

Wait counter:
- 4-bit counter, cleared on entry to FETCH, MEMRD or MEMWR.
- Increments every cycle the FSM waits with mem_ready=0.
- On reaching WAIT_MAX: set mem_timeout (sticky) and keep waiting. The FSM never aborts a memory access.

Boundary conditions:
- mem_ready high outside FETCH, MEMRD and MEMWR is ignored.
- rst_n low in any state, including mid-wait, forces IDLE immediately, zeroes all outputs and clears the counter.
- No partial register write may occur: because reset is asynchronous, RegWrite drops with rst_n.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL=6'b010001);
  - 4-bit state encodings, IDLE=0 through JAL=13;
  - ALUOp, ALUSrcB and PCSource encodings.
- Sub-module mips_ctrl_outdec: purely combinational state plus mem_ready -> control-vector decoder. The top level keeps the state register, next-state logic and wait counter.

Test Plan:
- Reset, release rst_n, mem_ready=1, opcode=000000: state sequence IDLE, FETCH, DECODE, RTYPE, ALUWB, FETCH; RegWrite=1 and RegDst=1 only in ALUWB.
- LW (100011) with mem_ready held low for 3 cycles in MEMRD: MEMRD lasts 4 cycles, MemRead/IorD stay high, MEMWB asserts MemtoReg=1, total 8 cycles, mem_timeout=0.
- JAL (010001): the third cycle shows PCWrite=1, PCSource=10 and RegWrite=1 for exactly one cycle, then FETCH.
- BEQ with zero=1 and then zero=0: PCWriteCond=1 and PCSource=01 in the BEQ cycle in both cases, 3-cycle instruction.
- Opcode 111111: DECODE -> FETCH, illegal_op high for exactly one cycle, no RegWrite/MemWrite.
- mem_ready=0 for 20 cycles in FETCH: mem_timeout sets after 15 wait cycles and stays set; asserting rst_n low mid-wait clears it and forces IDLE with all outputs 0 within the same cycle.
